// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache array with age-based LRU and victim reporting.
// Optional flush/writeback sequencer is enabled by defining DCACHE_SRAM_NWAY_FLUSH_EN;
// without it the flush/writeback ports are retained but tied off.
module dcache_sram_nway #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned LINE_W   = 256,
  localparam int unsigned SW      = $clog2(NUM_SETS),
  localparam int unsigned WW      = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [SW-1:0]     addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              hit_o,
  output logic [WW-1:0]     hit_way_o,
  output logic [LINE_W-1:0] data_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [SW-1:0]     wb_set_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic              flush_done_o
);

  localparam int unsigned IW = SW + WW;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WW-1:0]       age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   line_q  [NUM_SETS][NUM_WAYS];

  logic          busy;
  logic          wb_clear;
  logic [SW-1:0] fl_set;
  logic [WW-1:0] fl_way;

  logic          hit_raw;
  logic [WW-1:0] hit_way;
  logic          vic_found;
  logic [WW-1:0] vic_way;
  logic [WW-1:0] acc_way;
  logic          acc, wr_en, lru_upd;
  logic [WW-1:0] age_new [NUM_WAYS];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_raw = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit_raw && valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
        hit_raw = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the oldest way.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !valid_q[addr_i][w]) begin
        vic_found = 1'b1;
        vic_way   = WW'(w);
      end
    end
    if (!vic_found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (age_q[addr_i][w] == WW'(NUM_WAYS - 1)) vic_way = WW'(w);
      end
    end
  end

  assign acc     = enable_i & ~busy;
  assign wr_en   = acc & write_i;
  assign lru_upd = wr_en | (acc & hit_raw);
  assign acc_way = hit_raw ? hit_way : vic_way;

  // Ages after touching acc_way: it becomes youngest, younger ones shift up.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      age_new[w] = age_q[addr_i][w];
      if (WW'(w) == acc_way) begin
        age_new[w] = '0;
      end else if (age_q[addr_i][w] < age_q[addr_i][acc_way]) begin
        age_new[w] = age_q[addr_i][w] + WW'(1);
      end
    end
  end

  assign hit_o          = hit_raw & ~busy;
  assign hit_way_o      = hit_o ? hit_way : '0;
  assign data_o         = hit_o ? line_q[addr_i][hit_way] : '0;
  assign victim_valid_o = valid_q[addr_i][vic_way];
  assign victim_dirty_o = dirty_q[addr_i][vic_way];
  assign victim_tag_o   = tag_q[addr_i][vic_way];
  assign victim_data_o  = line_q[addr_i][vic_way];

  // Valid/dirty/age state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WW'(w);
      end
    end else begin
      if (wr_en) begin
        valid_q[addr_i][acc_way] <= 1'b1;
        dirty_q[addr_i][acc_way] <= hit_raw ? (dirty_q[addr_i][acc_way] | dirty_i) : dirty_i;
      end
      if (lru_upd) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) age_q[addr_i][w] <= age_new[w];
      end
      if (wb_clear) dirty_q[fl_set][fl_way] <= 1'b0;
    end
  end

  // Tag and line storage; contents are qualified by valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[addr_i][acc_way]  <= tag_i;
      line_q[addr_i][acc_way] <= data_i;
    end
  end

`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
  typedef enum logic [1:0] {FL_IDLE, FL_SCAN, FL_WB, FL_DONE} fl_state_e;

  fl_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wb_valid;

  assign fl_set = idx_q[IW-1:WW];
  assign fl_way = idx_q[WW-1:0];

  // Flush state and entry index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FL_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Walk entries set-major, stopping on each dirty line until it is accepted.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wb_clear     = 1'b0;
    wb_valid     = 1'b0;
    flush_done_o = 1'b0;
    unique case (state_q)
      FL_IDLE: begin
        if (flush_i) begin
          state_d = FL_SCAN;
          idx_d   = '0;
        end
      end
      FL_SCAN: begin
        if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
          state_d = FL_WB;
        end else if (idx_q == '1) begin
          state_d = FL_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      FL_WB: begin
        wb_valid = 1'b1;
        if (wb_ready_i) begin
          wb_clear = 1'b1;
          if (idx_q == '1) begin
            state_d = FL_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = FL_SCAN;
          end
        end
      end
      FL_DONE: begin
        flush_done_o = 1'b1;
        state_d      = FL_IDLE;
      end
      default: state_d = FL_IDLE;
    endcase
  end

  assign busy         = (state_q != FL_IDLE);
  assign flush_busy_o = busy;
  assign wb_valid_o   = wb_valid;
  assign wb_set_o     = wb_valid ? fl_set : '0;
  assign wb_tag_o     = wb_valid ? tag_q[fl_set][fl_way] : '0;
  assign wb_data_o    = wb_valid ? line_q[fl_set][fl_way] : '0;
`else
  logic unused_flush;

  assign unused_flush = flush_i ^ wb_ready_i;
  assign busy         = 1'b0;
  assign wb_clear     = 1'b0;
  assign fl_set       = '0;
  assign fl_way       = '0;
  assign flush_busy_o = 1'b0;
  assign wb_valid_o   = 1'b0;
  assign wb_set_o     = '0;
  assign wb_tag_o     = '0;
  assign wb_data_o    = '0;
  assign flush_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Scoreboard bench for dcache_sram_nway: a default 2-way instance and a 4-way instance.
module tb_dcache_sram_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 2-way default instance
  logic         a_en, a_wr, a_dirty, a_flush, a_wb_ready;
  logic [3:0]   a_addr;
  logic [23:0]  a_tag;
  logic [255:0] a_data;
  logic         a_hit, a_way, a_vvalid, a_vdirty, a_busy, a_wbv, a_done;
  logic [255:0] a_rdata, a_vdata, a_wbdata;
  logic [23:0]  a_vtag, a_wbtag;
  logic [3:0]   a_wbset;

  // 4-way instance
  logic         b_en, b_wr, b_dirty, b_flush, b_wb_ready;
  logic [1:0]   b_addr;
  logic [7:0]   b_tag;
  logic [31:0]  b_data;
  logic         b_hit, b_vvalid, b_vdirty, b_busy, b_wbv, b_done;
  logic [1:0]   b_way, b_wbset;
  logic [31:0]  b_rdata, b_vdata, b_wbdata;
  logic [7:0]   b_vtag, b_wbtag;

  dcache_sram_nway dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(a_en), .write_i(a_wr), .addr_i(a_addr),
    .tag_i(a_tag), .data_i(a_data), .dirty_i(a_dirty), .hit_o(a_hit), .hit_way_o(a_way),
    .data_o(a_rdata), .victim_valid_o(a_vvalid), .victim_dirty_o(a_vdirty),
    .victim_tag_o(a_vtag), .victim_data_o(a_vdata), .flush_i(a_flush),
    .flush_busy_o(a_busy), .wb_valid_o(a_wbv), .wb_ready_i(a_wb_ready),
    .wb_set_o(a_wbset), .wb_tag_o(a_wbtag), .wb_data_o(a_wbdata), .flush_done_o(a_done)
  );

  dcache_sram_nway #(.NUM_SETS(4), .NUM_WAYS(4), .TAG_W(8), .LINE_W(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(b_en), .write_i(b_wr), .addr_i(b_addr),
    .tag_i(b_tag), .data_i(b_data), .dirty_i(b_dirty), .hit_o(b_hit), .hit_way_o(b_way),
    .data_o(b_rdata), .victim_valid_o(b_vvalid), .victim_dirty_o(b_vdirty),
    .victim_tag_o(b_vtag), .victim_data_o(b_vdata), .flush_i(b_flush),
    .flush_busy_o(b_busy), .wb_valid_o(b_wbv), .wb_ready_i(b_wb_ready),
    .wb_set_o(b_wbset), .wb_tag_o(b_wbtag), .wb_data_o(b_wbdata), .flush_done_o(b_done)
  );

  typedef enum int {
    P_A_HIT, P_A_WAY, P_A_DATA, P_A_VVALID, P_A_VDIRTY, P_A_VTAG, P_A_VDATA,
    P_A_BUSY, P_A_WBV, P_A_DONE, P_A_WBSET, P_B_HIT, P_B_WAY, P_B_DATA, P_B_VVALID, P_B_VTAG
  } probe_e;

  typedef struct {
    probe_e       p;
    string        name;
    logic [255:0] exp;
  } exp_t;

  typedef struct {
    logic [3:0]   set;
    logic [23:0]  tag;
    logic [255:0] data;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  logic [255:0] L1, L2, L3, L4, L5, L6, L7, L8;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [255:0] probe(input probe_e p);
    logic [255:0] v;
    v = '0;
    case (p)
      P_A_HIT:    v[0] = a_hit;
      P_A_WAY:    v[0] = a_way;
      P_A_DATA:   v = a_rdata;
      P_A_VVALID: v[0] = a_vvalid;
      P_A_VDIRTY: v[0] = a_vdirty;
      P_A_VTAG:   v[23:0] = a_vtag;
      P_A_VDATA:  v = a_vdata;
      P_A_BUSY:   v[0] = a_busy;
      P_A_WBV:    v[0] = a_wbv;
      P_A_DONE:   v[0] = a_done;
      P_A_WBSET:  v[3:0] = a_wbset;
      P_B_HIT:    v[0] = b_hit;
      P_B_WAY:    v[1:0] = b_way;
      P_B_DATA:   v[31:0] = b_rdata;
      P_B_VVALID: v[0] = b_vvalid;
      P_B_VTAG:   v[7:0] = b_vtag;
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Monitor: drains pending expectations and checks every writeback handshake.
  always @(negedge clk) begin
    exp_t e;
    wb_t  w;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, probe(e.p), e.exp);
    end
    if (a_wbv && a_wb_ready) begin
      hs_cnt++;
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 256'(a_wbset), 256'hFFFF);
      end else begin
        w = wb_q.pop_front();
        check("wb_set", 256'(a_wbset), 256'(w.set));
        check("wb_tag", 256'(a_wbtag), 256'(w.tag));
        check("wb_data", a_wbdata, w.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input probe_e p, input string n, input logic [255:0] v);
    exp_q.push_back('{p, n, v});
  endtask

  task automatic a_set(input logic en, input logic wr, input logic [3:0] addr,
                       input logic [23:0] tag, input logic [255:0] data, input logic dirty);
    a_en = en; a_wr = wr; a_addr = addr; a_tag = tag; a_data = data; a_dirty = dirty;
  endtask

  task automatic b_set(input logic en, input logic wr, input logic [1:0] addr,
                       input logic [7:0] tag, input logic [31:0] data);
    b_en = en; b_wr = wr; b_addr = addr; b_tag = tag; b_data = data; b_dirty = 1'b0;
  endtask

  // Pulse flush, then serve writebacks with three idle-ready cycles each.
  task automatic run_flush(output int busy_cyc, output int done_cnt, output bit timed_out);
    int wait_c;
    busy_cyc  = 0;
    done_cnt  = 0;
    wait_c    = 0;
    timed_out = 1'b1;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!a_busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cyc++;
      if (a_done) done_cnt++;
      a_set(1'b0, 1'b0, 4'd0, 24'h0, '0, 1'b0);
      if (c == 2) begin
        a_set(1'b1, 1'b0, 4'd5, 24'hA, '0, 1'b0);
        push_exp(P_A_HIT, "hit_while_busy", 256'd0);
      end
      if (a_wbv) begin
        a_wb_ready = (wait_c == 3);
        wait_c     = (wait_c == 3) ? 0 : wait_c + 1;
      end else begin
        a_wb_ready = 1'b0;
      end
      tick();
    end
    a_set(1'b0, 1'b0, 4'd0, 24'h0, '0, 1'b0);
    a_wb_ready = 1'b0;
  endtask

  initial begin
    int bc, dc, hs_before;
    bit to;
    L1 = {8{32'h1111_0001}}; L2 = {8{32'h2222_0002}}; L3 = {8{32'h3333_0003}};
    L4 = {8{32'h4444_0004}}; L5 = {8{32'h5555_0005}}; L6 = {8{32'h6666_0006}};
    L7 = {8{32'h7777_0007}}; L8 = {8{32'h8888_0008}};
    rst_n = 1'b0;
    a_flush = 1'b1; a_wb_ready = 1'b0;
    b_flush = 1'b0; b_wb_ready = 1'b0;
    a_set(1'b1, 1'b0, 4'd3, 24'h12, '0, 1'b0);
    b_set(1'b1, 1'b0, 2'd2, 8'h1, '0);

    // Outputs while reset is held
    tick();
    push_exp(P_A_HIT, "rst_hit", 256'd0);
    push_exp(P_A_WAY, "rst_way", 256'd0);
    push_exp(P_A_DATA, "rst_data", 256'd0);
    push_exp(P_A_VVALID, "rst_vvalid", 256'd0);
    push_exp(P_A_VDIRTY, "rst_vdirty", 256'd0);
    push_exp(P_A_BUSY, "rst_busy", 256'd0);
    push_exp(P_A_WBV, "rst_wbv", 256'd0);
    push_exp(P_A_DONE, "rst_done", 256'd0);
    push_exp(P_A_WBSET, "rst_wbset", 256'd0);
    push_exp(P_B_HIT, "rst_b_hit", 256'd0);
    push_exp(P_B_VVALID, "rst_b_vvalid", 256'd0);
    tick();
    a_flush = 1'b0;
    rst_n = 1'b1;
    tick();

    // Lookup after reset
    a_set(1'b1, 1'b0, 4'd3, 24'h12, '0, 1'b0);
    push_exp(P_A_HIT, "post_rst_hit", 256'd0);
    push_exp(P_A_VVALID, "post_rst_vvalid", 256'd0);
    push_exp(P_A_DATA, "post_rst_data", 256'd0);
    tick();

    // Write then read back set 5
    a_set(1'b1, 1'b1, 4'd5, 24'hA, L1, 1'b0);
    push_exp(P_A_HIT, "wr5_miss", 256'd0);
    tick();
    a_set(1'b1, 1'b0, 4'd5, 24'hA, '0, 1'b0);
    push_exp(P_A_HIT, "rd5_hit", 256'd1);
    push_exp(P_A_WAY, "rd5_way", 256'd0);
    push_exp(P_A_DATA, "rd5_data", L1);
    push_exp(P_A_VVALID, "rd5_vvalid", 256'd0);
    tick();
    a_set(1'b1, 1'b1, 4'd5, 24'hA, L2, 1'b1);
    push_exp(P_A_HIT, "wr5_hit", 256'd1);
    tick();
    a_set(1'b0, 1'b1, 4'd5, 24'hA, L3, 1'b0);
    tick();
    a_set(1'b1, 1'b0, 4'd5, 24'hA, '0, 1'b0);
    push_exp(P_A_DATA, "rd5_after_disabled_wr", L2);
    tick();
    a_set(1'b1, 1'b0, 4'd5, 24'hB, '0, 1'b0);
    push_exp(P_A_HIT, "rd5_miss_hit", 256'd0);
    push_exp(P_A_DATA, "rd5_miss_data", 256'd0);
    push_exp(P_A_WAY, "rd5_miss_way", 256'd0);
    tick();

    // Set 0: eviction of a dirty line, then LRU after a read hit
    a_set(1'b1, 1'b1, 4'd0, 24'h100, L4, 1'b1);
    tick();
    a_set(1'b1, 1'b1, 4'd0, 24'h200, L5, 1'b0);
    push_exp(P_A_VVALID, "s0_fill_vvalid", 256'd0);
    tick();
    a_set(1'b1, 1'b1, 4'd0, 24'h300, L6, 1'b0);
    push_exp(P_A_HIT, "s0_evict_hit", 256'd0);
    push_exp(P_A_VVALID, "s0_evict_vvalid", 256'd1);
    push_exp(P_A_VDIRTY, "s0_evict_vdirty", 256'd1);
    push_exp(P_A_VTAG, "s0_evict_vtag", 256'h100);
    push_exp(P_A_VDATA, "s0_evict_vdata", L4);
    tick();
    a_set(1'b1, 1'b0, 4'd0, 24'h300, '0, 1'b0);
    push_exp(P_A_HIT, "s0_rd300_hit", 256'd1);
    push_exp(P_A_WAY, "s0_rd300_way", 256'd0);
    push_exp(P_A_DATA, "s0_rd300_data", L6);
    tick();
    a_set(1'b1, 1'b0, 4'd0, 24'h200, '0, 1'b0);
    push_exp(P_A_WAY, "s0_rd200_way", 256'd1);
    push_exp(P_A_DATA, "s0_rd200_data", L5);
    tick();
    a_set(1'b1, 1'b0, 4'd0, 24'h100, '0, 1'b0);
    push_exp(P_A_HIT, "s0_rd100_hit", 256'd0);
    push_exp(P_A_VTAG, "s0_lru_vtag", 256'h300);
    push_exp(P_A_VDIRTY, "s0_lru_vdirty", 256'd0);
    tick();

    // Set 7: write hit keeps an existing dirty bit
    a_set(1'b1, 1'b1, 4'd7, 24'h70, L7, 1'b1);
    tick();
    a_set(1'b1, 1'b1, 4'd7, 24'h70, L8, 1'b0);
    tick();
    a_set(1'b1, 1'b1, 4'd7, 24'h71, L1, 1'b0);
    tick();
    a_set(1'b1, 1'b0, 4'd7, 24'h72, '0, 1'b0);
    push_exp(P_A_VVALID, "s7_vvalid", 256'd1);
    push_exp(P_A_VDIRTY, "s7_vdirty_or", 256'd1);
    push_exp(P_A_VTAG, "s7_vtag", 256'h70);
    push_exp(P_A_VDATA, "s7_vdata", L8);
    tick();
    a_set(1'b0, 1'b0, 4'd0, 24'h0, '0, 1'b0);
    tick();

    // Flush with two dirty lines (set 5 way 0, set 7 way 0)
`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
    wb_q.push_back('{4'd5, 24'hA, L2});
    wb_q.push_back('{4'd7, 24'h70, L8});
    run_flush(bc, dc, to);
    tick();
    check("flush1_timeout", 256'(to), 256'd0);
    check("flush1_busy_cycles", 256'(bc), 256'd41);
    check("flush1_done_pulses", 256'(dc), 256'd1);
    check("flush1_handshakes", 256'(hs_cnt), 256'd2);
    check("flush1_wb_left", 256'(wb_q.size()), 256'd0);
    hs_before = hs_cnt;
    run_flush(bc, dc, to);
    tick();
    check("flush2_timeout", 256'(to), 256'd0);
    check("flush2_busy_cycles", 256'(bc), 256'd33);
    check("flush2_done_pulses", 256'(dc), 256'd1);
    check("flush2_handshakes", 256'(hs_cnt - hs_before), 256'd0);
`else
    run_flush(bc, dc, to);
    check("noflush_busy_cycles", 256'(bc), 256'd0);
    check("noflush_done_pulses", 256'(dc), 256'd0);
    a_wb_ready = 1'b1;
    a_set(1'b1, 1'b0, 4'd5, 24'hA, '0, 1'b0);
    push_exp(P_A_HIT, "noflush_hit", 256'd1);
    push_exp(P_A_WBV, "noflush_wbv", 256'd0);
    push_exp(P_A_WBSET, "noflush_wbset", 256'd0);
    tick();
    a_wb_ready = 1'b0;
    a_set(1'b0, 1'b0, 4'd0, 24'h0, '0, 1'b0);
    tick();
    check("noflush_handshakes", 256'(hs_cnt), 256'd0);
`endif

    // Reset asserted while a flush is in flight
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    tick();
`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
    push_exp(P_A_BUSY, "abort_busy_before", 256'd1);
`else
    push_exp(P_A_BUSY, "abort_busy_before", 256'd0);
`endif
    tick();
    rst_n = 1'b0;
    push_exp(P_A_BUSY, "abort_busy_in_rst", 256'd0);
    push_exp(P_A_DONE, "abort_done_in_rst", 256'd0);
    tick();
    rst_n = 1'b1;
    dc = 0;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_done) dc++;
      if (a_busy) bc++;
      tick();
    end
    check("abort_done_pulses", 256'(dc), 256'd0);
    check("abort_busy_cycles", 256'(bc), 256'd0);
    a_set(1'b1, 1'b0, 4'd5, 24'hA, '0, 1'b0);
    push_exp(P_A_HIT, "abort_cache_cleared", 256'd0);
    tick();
    a_set(1'b0, 1'b0, 4'd0, 24'h0, '0, 1'b0);

    // 4-way LRU replacement in set 2
    for (int t = 1; t <= 4; t++) begin
      b_set(1'b1, 1'b1, 2'd2, 8'(t), 32'hB000_0000 | 32'(t));
      tick();
    end
    b_set(1'b1, 1'b0, 2'd2, 8'd1, '0);
    push_exp(P_B_HIT, "b_rd1_hit", 256'd1);
    push_exp(P_B_WAY, "b_rd1_way", 256'd0);
    push_exp(P_B_DATA, "b_rd1_data", 256'hB000_0001);
    tick();
    b_set(1'b1, 1'b1, 2'd2, 8'd5, 32'hB000_0005);
    push_exp(P_B_HIT, "b_wr5_hit", 256'd0);
    push_exp(P_B_VVALID, "b_wr5_vvalid", 256'd1);
    push_exp(P_B_VTAG, "b_wr5_vtag", 256'd2);
    tick();
    b_set(1'b1, 1'b0, 2'd2, 8'd5, '0);
    push_exp(P_B_HIT, "b_rd5_hit", 256'd1);
    push_exp(P_B_WAY, "b_rd5_way", 256'd1);
    push_exp(P_B_DATA, "b_rd5_data", 256'hB000_0005);
    tick();
    b_set(1'b1, 1'b0, 2'd2, 8'd2, '0);
    push_exp(P_B_HIT, "b_rd2_evicted", 256'd0);
    push_exp(P_B_VTAG, "b_next_vtag", 256'd3);
    tick();
    b_set(1'b1, 1'b0, 2'd2, 8'd4, '0);
    push_exp(P_B_WAY, "b_rd4_way", 256'd3);
    tick();
    b_set(1'b0, 1'b0, 2'd0, 8'd0, '0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter NUM_WAYS, default 2, associativity (power of 2, 2..8).
REQ-003 SHALL have parameter TAG_W, default 24, stored tag width.
REQ-004 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-005 SHALL have ports (SW = log2 NUM_SETS, WW = max(1, log2 NUM_WAYS)):
  clk_i  in  1  sole clock, rising edge.
  rst_ni  in  1  asynchronous, active-low reset.
  enable_i  in  1  access strobe.
  write_i  in  1  1 = write/refill, 0 = read lookup.
  addr_i  in  SW  set index.
  tag_i  in  TAG_W  lookup/write tag.
  data_i  in  LINE_W  write line.
  dirty_i  in  1  dirty value for the written line.
  hit_o  out  1  lookup hit.
  hit_way_o  out  WW  matching way.
  data_o  out  LINE_W  hit line, else 0.
  victim_valid_o  out  1  victim entry valid.
  victim_dirty_o  out  1  victim entry dirty.
  victim_tag_o  out  TAG_W  victim tag.
  victim_data_o  out  LINE_W  victim line.
  flush_i  in  1  flush request pulse.
  flush_busy_o  out  1  flush in progress.
  wb_valid_o  out  1  writeback line offered.
  wb_ready_i  in  1  writeback accepted.
  wb_set_o  out  SW  writeback set.
  wb_tag_o  out  TAG_W  writeback tag.
  wb_data_o  out  LINE_W  writeback line.
  flush_done_o  out  1  one-cycle flush-complete pulse.

Function
REQ-006 Per entry: valid, dirty, tag, line; per set: one age counter (WW bits) per way, always a permutation of 0..NUM_WAYS-1.
REQ-007 hit_o, hit_way_o, data_o SHALL be combinational from addr_i/tag_i: hit = some valid way with equal tag; otherwise data_o = 0 and hit_way_o = 0.
REQ-008 Victim way SHALL be the lowest-index invalid way if any exists, else the way with age NUM_WAYS-1; victim_* outputs combinational.
REQ-009 Write hit (enable_i & write_i & hit) SHALL replace the line at the next edge; dirty becomes old dirty OR dirty_i.
REQ-010 Write miss SHALL overwrite the victim way: valid=1, tag=tag_i, line=data_i, dirty=dirty_i; the caller samples victim_* in the same cycle for writeback.
REQ-011 Read miss SHALL change no state.
REQ-012 Read hit and every write SHALL update LRU: accessed way age 0; ways whose age was below the accessed way's old age increment; others unchanged.
REQ-013 enable_i low SHALL change no state.

Flush FSM
REQ-014 States IDLE, SCAN, WB, DONE; entry index counter walks set-major, way-minor, from 0 to NUM_SETS*NUM_WAYS-1.
REQ-015 IDLE: flush_i=1 -> SCAN, counter=0; flush_i in any other state is ignored.
REQ-016 SCAN: a valid and dirty entry -> WB; otherwise advance one entry per cycle; after the last entry -> DONE.
REQ-017 WB: wb_valid_o=1 with that entry's set/tag/line held stable; on wb_ready_i=1 clear dirty (valid kept) and advance or go to DONE; wb_ready_i=0 holds.
REQ-018 DONE: flush_done_o=1 for exactly one cycle -> IDLE.
REQ-019 flush_busy_o=1 in SCAN/WB/DONE; while busy, enable_i is ignored and hit_o=0.

Reset
REQ-020 rst_ni low SHALL asynchronously clear all valid/dirty bits, set age of way w to w in every set, and force the FSM to IDLE with the counter at 0.
REQ-021 During reset all outputs SHALL be 0 except victim_tag_o/victim_data_o; tag and line arrays need not be reset.
REQ-022 Reset asserted mid-flush SHALL abandon the flush with no flush_done_o pulse.

Configuration
REQ-023 Macro DCACHE_SRAM_NWAY_FLUSH_EN: defined -> REQ-014..019 implemented; undefined -> no FSM, ports retained, flush_busy_o/wb_valid_o/flush_done_o/wb_* tied 0, flush_i/wb_ready_i ignored.

Verification
REQ-024 After reset, read set 3 tag 0x12 -> hit_o=0, victim_valid_o=0, victim way 0.
REQ-025 Write set 5 tag 0xA (dirty 0), then read it -> hit_o=1, data_o equals written line, way 0.
REQ-026 NUM_WAYS=4: fill set 2 with tags 1..4, read tag 1, then miss-write tag 5 -> tag 2 evicted (victim_tag_o=2 in the write cycle).
REQ-027 NUM_WAYS=2: dirty write at set 0, miss-write fills way 1, third tag -> victim_dirty_o=1, victim_tag_o = first tag.
REQ-028 Flush with 2 dirty lines, wb_ready_i low 3 cycles each -> exactly 2 wb handshakes in index order, dirty cleared, flush_done_o once.
REQ-029 Flush on clean cache with defaults -> flush_busy_o high 33 cycles (32 SCAN + 1 DONE), no wb_valid_o.
